// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: run-state encoding and CPU-wide constants.
package pipeline_ctrl_pkg;

  localparam int          DEF_REG_AW  = 5;
  localparam logic [31:0] BOOT_VECTOR = 32'h0040_0000;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } cpu_state_e;

endpackage

// File: rtl/pipeline_ctrl_run_ctrl_fsm.sv
// Run-control FSM: halt/run/single-step/restart sequencing and the step_done pulse.
module run_ctrl_fsm
  import pipeline_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run_req,
  input  logic       step_req,
  input  logic       halt_req,
  input  logic       restart_req,
  input  logic       adv,
  input  logic       bp_hit,
  output cpu_state_e state,
  output logic       step_done
);

  cpu_state_e state_q, state_d;
  logic       step_done_q, step_done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HALT;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_done_q <= step_done_d;
    end
  end

  // Restart and halt override everything; a step only completes on an unstalled cycle.
  always_comb begin
    state_d     = state_q;
    step_done_d = 1'b0;
    if (restart_req || halt_req) begin
      state_d = ST_HALT;
    end else begin
      case (state_q)
        ST_HALT: begin
          if (run_req)       state_d = ST_RUN;
          else if (step_req) state_d = ST_STEP;
        end
        ST_RUN: begin
          if (bp_hit) state_d = ST_HALT;
        end
        ST_STEP: begin
          if (adv) begin
            state_d     = ST_HALT;
            step_done_d = 1'b1;
          end
        end
        default: state_d = ST_HALT;
      endcase
    end
  end

  always_comb begin
    state     = state_q;
    step_done = step_done_q;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: run control, hazard priority and performance counters for the 5-stage CPU.
// Optional breakpoint support is compiled in with `define BREAKPOINT_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              halt_req,
  input  logic              restart_req,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  input  logic              bp_valid,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       if_pc,
  output logic              pc_en,
  output logic              pc_stall,
  output logic              pc_flush,
  output logic              ifid_en,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_stall,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic              exmem_stall,
  output logic              memwb_en,
  output logic              memwb_stall,
  output logic [1:0]        cpu_state,
  output logic              step_done,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  cpu_state_e state;
  logic       en, adv, lu, bubble, bp_hit;

  assign en     = (state == ST_RUN) || (state == ST_STEP);
  assign adv    = en && !mem_busy;
  assign lu     = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign bubble = lu && adv && !ex_redirect && !restart_req;

`ifdef BREAKPOINT_EN
  assign bp_hit = (state == ST_RUN) && bp_valid && (if_pc == bp_addr) && adv;
`else
  logic unused_bp;
  assign unused_bp = &{1'b0, bp_valid, bp_addr, if_pc};
  assign bp_hit    = 1'b0;
`endif

  run_ctrl_fsm u_fsm (
    .clk         (clk),
    .rst         (rst),
    .run_req     (run_req),
    .step_req    (step_req),
    .halt_req    (halt_req),
    .restart_req (restart_req),
    .adv         (adv),
    .bp_hit      (bp_hit),
    .state       (state),
    .step_done   (step_done)
  );

  assign cpu_state = state;

  // Priority: restart > mem_busy > ex_redirect > load-use; nothing is asserted while halted.
  always_comb begin
    pc_en       = en && !bp_hit;
    ifid_en     = en;
    idex_en     = en;
    exmem_en    = en;
    memwb_en    = en;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    memwb_stall = 1'b0;
    pc_flush    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (restart_req) begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      pc_flush   = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (en && mem_busy) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_stall = 1'b1;
    end else if (adv && ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (adv && lu) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (adv)    cycle_cnt  <= cycle_cnt + CNT_W'(1);
      if (bubble) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random traffic against a rule-level model.
module tb_pipeline_ctrl;

  localparam int          M_HALT = 0;
  localparam int          M_RUN  = 1;
  localparam int          M_STEP = 2;
  localparam logic [31:0] BOOT   = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rstSig;
  logic        runReq, stepReq, haltReq, restartReq;
  logic [4:0]  idRs1, idRs2, exRd;
  logic        exMemRead, exRedirect, memBusy;
  logic        bpValid;
  logic [31:0] bpAddr, ifPc;
  logic        pcEn, pcStall, pcFlush, ifidEn, ifidStall, ifidFlush;
  logic        idexEn, idexStall, idexFlush, exmemEn, exmemStall, memwbEn, memwbStall;
  logic [1:0]  cpuState;
  logic        stepDone;
  logic [31:0] cycleCnt, bubbleCnt;

  int          assertCount = 0;
  int          failCount   = 0;

  int          mState;
  bit          mStepDone;
  logic [31:0] mCycles, mBubbles;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rstSig),
    .run_req(runReq), .step_req(stepReq), .halt_req(haltReq), .restart_req(restartReq),
    .id_rs1(idRs1), .id_rs2(idRs2), .ex_rd(exRd),
    .ex_mem_read(exMemRead), .ex_redirect(exRedirect), .mem_busy(memBusy),
    .bp_valid(bpValid), .bp_addr(bpAddr), .if_pc(ifPc),
    .pc_en(pcEn), .pc_stall(pcStall), .pc_flush(pcFlush),
    .ifid_en(ifidEn), .ifid_stall(ifidStall), .ifid_flush(ifidFlush),
    .idex_en(idexEn), .idex_stall(idexStall), .idex_flush(idexFlush),
    .exmem_en(exmemEn), .exmem_stall(exmemStall), .memwb_en(memwbEn), .memwb_stall(memwbStall),
    .cpu_state(cpuState), .step_done(stepDone), .cycle_cnt(cycleCnt), .bubble_cnt(bubbleCnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit bpStops();
    bit hit = 1'b0;
`ifdef BREAKPOINT_EN
    hit = (mState == M_RUN) && bpValid && (ifPc == bpAddr) && !memBusy;
`endif
    return hit;
  endfunction

  // Expected control vector {pc en/stall/flush, ifid en/stall/flush, idex en/stall/flush, exmem en/stall, memwb en/stall}.
  function automatic logic [12:0] expectedCtrl();
    bit active = (mState != M_HALT);
    bit go     = active && !memBusy;
    bit hazard = exMemRead && (exRd != 0) && ((exRd == idRs1) || (exRd == idRs2));
    bit [2:0] pcV, ifidV, idexV;
    bit [1:0] exmemV, memwbV;
    if (restartReq) begin
      pcV = 3'b101; ifidV = 3'b101; idexV = 3'b101; exmemV = 2'b10; memwbV = 2'b10;
    end else begin
      pcV    = {active && !bpStops(), 2'b00};
      ifidV  = {active, 2'b00};
      idexV  = {active, 2'b00};
      exmemV = {active, 1'b0};
      memwbV = {active, 1'b0};
      if (active && memBusy) begin
        pcV[1] = 1; ifidV[1] = 1; idexV[1] = 1; exmemV[0] = 1; memwbV[0] = 1;
      end else if (go && exRedirect) begin
        ifidV[0] = 1; idexV[0] = 1;
      end else if (go && hazard) begin
        pcV[1] = 1; ifidV[1] = 1; idexV[0] = 1;
      end
    end
    return {pcV, ifidV, idexV, exmemV, memwbV};
  endfunction

  task automatic modelReset();
    mState = M_HALT; mStepDone = 0; mCycles = 0; mBubbles = 0;
  endtask

  task automatic modelAdvance();
    bit go     = (mState != M_HALT) && !memBusy;
    bit hazard = exMemRead && (exRd != 0) && ((exRd == idRs1) || (exRd == idRs2));
    int nxt    = mState;
    if (rstSig) begin
      modelReset();
      return;
    end
    if (go) mCycles = mCycles + 1;
    if (go && hazard && !exRedirect && !restartReq) mBubbles = mBubbles + 1;
    mStepDone = (mState == M_STEP) && go && !restartReq && !haltReq;
    if (restartReq || haltReq)               nxt = M_HALT;
    else if (mState == M_HALT && runReq)     nxt = M_RUN;
    else if (mState == M_HALT && stepReq)    nxt = M_STEP;
    else if (mState == M_STEP && go)         nxt = M_HALT;
    else if (mState == M_RUN && bpStops())   nxt = M_HALT;
    mState = nxt;
  endtask

  task automatic checkAgainstModel();
    checkOutput("ctrl", {pcEn, pcStall, pcFlush, ifidEn, ifidStall, ifidFlush, idexEn, idexStall,
                         idexFlush, exmemEn, exmemStall, memwbEn, memwbStall}, expectedCtrl());
    checkOutput("cpu_state", cpuState, mState);
    checkOutput("step_done", stepDone, mStepDone);
    checkOutput("cycle_cnt", cycleCnt, mCycles);
    checkOutput("bubble_cnt", bubbleCnt, mBubbles);
  endtask

  // Called at a falling edge: drive inputs, check, take the rising edge, return at the next falling edge.
  task automatic applyStimulus(input bit run, input bit step, input bit halt, input bit restart,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input bit memRead, input bit redirect, input bit busy);
    runReq = run; stepReq = step; haltReq = halt; restartReq = restart;
    idRs1 = rs1; idRs2 = rs2; exRd = rd;
    exMemRead = memRead; exRedirect = redirect; memBusy = busy;
    #2;
    checkAgainstModel();
    @(posedge clk);
    modelAdvance();
    @(negedge clk);
    rstSig = 0; runReq = 0; stepReq = 0; haltReq = 0; restartReq = 0;
    exMemRead = 0; exRedirect = 0; memBusy = 0; bpValid = 0;
    #1;
  endtask

  logic [31:0] snap;

  initial begin
    rstSig = 1; runReq = 0; stepReq = 0; haltReq = 0; restartReq = 0;
    idRs1 = 0; idRs2 = 0; exRd = 0; exMemRead = 0; exRedirect = 0; memBusy = 0;
    bpValid = 0; bpAddr = BOOT + 32'h8; ifPc = BOOT;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_state", cpuState, 2'b00);
    checkOutput("rst_en", {pcEn, ifidEn, idexEn, exmemEn, memwbEn}, 5'b0);
    checkOutput("rst_stall_flush", {pcStall, pcFlush, ifidStall, ifidFlush, idexStall, idexFlush,
                                    exmemStall, memwbStall}, 8'b0);
    checkOutput("rst_counters", {cycleCnt, bubbleCnt}, 64'h0);
    checkOutput("rst_step_done", stepDone, 1'b0);
    rstSig = 0;
    modelReset();

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("run_state", cpuState, 2'b01);
    checkOutput("run_pc_en", pcEn, 1'b1);

    snap = bubbleCnt;
    applyStimulus(0, 0, 0, 0, 5'd1, 5'd5, 5'd5, 1, 0, 0);
    checkOutput("lu_bubble", bubbleCnt, snap + 1);
    applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    checkOutput("lu_x0_no_bubble", bubbleCnt, snap + 1);
    applyStimulus(0, 0, 0, 0, 5'd3, 5'd7, 5'd3, 1, 1, 0);
    checkOutput("redirect_no_bubble", bubbleCnt, snap + 1);

    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    snap = cycleCnt;
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("step_busy_state", cpuState, 2'b10);
    checkOutput("step_busy_cycles", cycleCnt, snap);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("step_halt", cpuState, 2'b00);
    checkOutput("step_done_pulse", stepDone, 1'b1);
    checkOutput("step_cycles", cycleCnt, snap + 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("run_halt_same", cpuState, 2'b00);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("restart_halt", cpuState, 2'b00);

`ifdef BREAKPOINT_EN
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ifPc = BOOT + 32'h8; bpValid = 1;
    #1 checkOutput("bp_pc_en", pcEn, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("bp_halt", cpuState, 2'b00);
    bpValid = 1;
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    bpValid = 1;
    #1 checkOutput("bp_step_advance", {pcEn, pcStall}, 2'b10);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ifPc = BOOT + 32'hC;
    checkOutput("bp_step_done", stepDone, 1'b1);
`endif

    for (int i = 0; i < 400; i++) begin
      rstSig  = ($urandom_range(0, 63) == 0);
      bpValid = $urandom_range(0, 1);
      ifPc    = BOOT + 32'($urandom_range(0, 3)) * 4;
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
